// File: rtl/sparse_token_pkg.sv
// Token classification and shared types for the fiber_access sparse stream.
// Used by the sink today and by the matching stream source later.
package sparse_token_pkg;

    localparam int TOKEN_W = 17;

    localparam logic [TOKEN_W-1:0] DONE_TOKEN = 17'h10100;
    localparam logic [TOKEN_W-1:0] STOP_MASK  = 17'h1ff00;
    localparam logic [TOKEN_W-1:0] STOP_MATCH = 17'h10000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } sink_state_t;

    typedef enum logic {
        PH_READY = 1'b0,
        PH_STALL = 1'b1
    } stall_phase_t;

    typedef struct packed {
        sink_state_t  state;
        stall_phase_t stall_phase;
    } sink_dbg_t;

    function automatic logic is_data(input logic [TOKEN_W-1:0] tok);
        return !tok[TOKEN_W-1];
    endfunction

    // Stop tokens carry their level in bits [7:0]; bits [15:8] must be zero.
    function automatic logic is_stop(input logic [TOKEN_W-1:0] tok);
        return (tok & STOP_MASK) == STOP_MATCH;
    endfunction

    function automatic logic is_done(input logic [TOKEN_W-1:0] tok);
        return tok == DONE_TOKEN;
    endfunction

endpackage

// File: rtl/stream_stall_gen.sv
// Programmable backpressure pattern: cfg_period ready cycles, then cfg_len stall cycles.
// Either config value at zero disables stalling; config is resampled at phase boundaries.
module stream_stall_gen
    import sparse_token_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    input  logic [7:0]   cfg_period,
    input  logic [7:0]   cfg_len,
    output logic         stall_n,
    output stall_phase_t phase_o
);

    stall_phase_t phase_q, phase_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [7:0]   per_q, per_d;
    logic [7:0]   len_q, len_d;
    logic         never_stall;

    assign never_stall = (per_q == 8'd0) || (len_q == 8'd0);

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        len_d   = len_q;
        if (en) begin
            if (phase_q == PH_READY) begin
                if (never_stall) begin
                    // No phase boundary exists while disabled, so keep tracking config.
                    per_d = cfg_period;
                    len_d = cfg_len;
                    cnt_d = 8'd0;
                end else if (cnt_q == per_q - 8'd1) begin
                    cnt_d = 8'd0;
                    len_d = cfg_len;
                    if (cfg_len == 8'd0) begin
                        per_d = cfg_period;
                    end else begin
                        phase_d = PH_STALL;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end else begin
                if (cnt_q == len_q - 8'd1) begin
                    phase_d = PH_READY;
                    cnt_d   = 8'd0;
                    per_d   = cfg_period;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            phase_q <= PH_READY;
            cnt_q   <= 8'd0;
            per_q   <= cfg_period;
            len_q   <= cfg_len;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            len_q   <= len_d;
        end
    end

    assign stall_n = (phase_q == PH_READY);
    assign phase_o = phase_q;

endmodule

// File: rtl/sparse_stream_sink.sv
// Capture sink for the 17-bit sparse token stream: buffers accepted tokens, counts
// data/stop tokens and receive cycles, and raises done after TX_NUM DONE tokens.
module sparse_stream_sink
    import sparse_token_pkg::*;
#(
    parameter int DATA_WIDTH = 17,
    parameter int DEPTH      = 256,
    parameter int TX_NUM     = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clk_en,
    input  logic                       flush,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       valid_in,
    output logic                       ready_out,
    input  logic [7:0]                 cfg_stall_period,
    input  logic [7:0]                 cfg_stall_len,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic [CNT_WIDTH-1:0]       token_count,
    output logic [CNT_WIDTH-1:0]       stop_count,
    output logic [CNT_WIDTH-1:0]       cycle_count,
    output logic [$clog2(DEPTH):0]     wr_ptr,
    output logic                       done,
    output logic                       overflow,
    output sink_dbg_t                  dbg_o
);

    localparam int AW  = $clog2(DEPTH);
    localparam int DSW = $clog2(TX_NUM + 1);
    localparam logic [DSW-1:0] DONE_LAST = DSW'(TX_NUM - 1);

    sink_state_t            state_q, state_d;
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [CNT_WIDTH-1:0]   token_q, token_d;
    logic [CNT_WIDTH-1:0]   stop_q, stop_d;
    logic [CNT_WIDTH-1:0]   cycle_q, cycle_d;
    logic [DSW-1:0]         dseen_q, dseen_d;
    logic                   overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0]  rd_data_q;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic                   stall_n;
    stall_phase_t           stall_phase;
    logic                   accept;
    logic                   mem_full;
    logic                   wr_en;

    // Handshake: a token transfers on a clock edge where valid_in, ready_out and clk_en
    // are all high. ready_out depends only on clk_en, the FSM state and the stall
    // generator, never on valid_in; a flush cycle drops whatever is presented.
    assign ready_out = clk_en && (state_q != DONE) && stall_n;
    assign accept    = valid_in && ready_out && !flush && !rst;
    assign mem_full  = wr_ptr_q[AW];
    assign wr_en     = accept && !mem_full;

    stream_stall_gen u_stall_gen (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush),
        .en         (clk_en && (state_q != DONE)),
        .cfg_period (cfg_stall_period),
        .cfg_len    (cfg_stall_len),
        .stall_n    (stall_n),
        .phase_o    (stall_phase)
    );

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        token_d    = token_q;
        stop_d     = stop_q;
        cycle_d    = cycle_q;
        dseen_d    = dseen_q;
        overflow_d = overflow_q;

        // The cycle that accepts the first token is counted as the first receive cycle.
        if (clk_en && ((state_q == RECV) || (state_q == IDLE && accept))) begin
            cycle_d = cycle_q + CNT_WIDTH'(1);
        end

        if (accept) begin
            if (state_q == IDLE) begin
                state_d = RECV;
            end
            if (mem_full) begin
                overflow_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (is_data(data_in)) begin
                token_d = token_q + CNT_WIDTH'(1);
            end
            if (is_stop(data_in)) begin
                stop_d = stop_q + CNT_WIDTH'(1);
            end
            if (is_done(data_in)) begin
                if (dseen_q == DONE_LAST) begin
                    state_d = DONE;
                end else begin
                    dseen_d = dseen_q + DSW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            token_q    <= '0;
            stop_q     <= '0;
            cycle_q    <= '0;
            dseen_q    <= '0;
            overflow_q <= 1'b0;
            rd_data_q  <= '0;
        end else if (clk_en) begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            token_q    <= token_d;
            stop_q     <= stop_d;
            cycle_q    <= cycle_d;
            dseen_q    <= dseen_d;
            overflow_q <= overflow_d;
            rd_data_q  <= mem[rd_addr];
        end
    end

    // Capture buffer is deliberately not reset; only wr_ptr defines valid contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= data_in;
        end
    end

    assign rd_data           = rd_data_q;
    assign token_count       = token_q;
    assign stop_count        = stop_q;
    assign cycle_count       = cycle_q;
    assign wr_ptr            = wr_ptr_q;
    assign done              = (state_q == DONE);
    assign overflow          = overflow_q;
    assign dbg_o.state       = state_q;
    assign dbg_o.stall_phase = stall_phase;

endmodule

// File: tb/tb_sparse_stream_sink.sv
// Bench for sparse_stream_sink: three parameterisations share one stimulus stream and
// are compared every cycle against a behavioural model, plus directed scenario checks.
module tb_sparse_stream_sink;
    import sparse_token_pkg::*;

    // ---------------- clock / reset / inputs ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_en = 1'b1;
    logic        flush = 1'b0;
    logic [16:0] data_in = '0;
    logic        valid_in = 1'b0;
    logic [7:0]  cfg_p = 8'd0;
    logic [7:0]  cfg_l = 8'd0;
    logic [7:0]  rd_addr = 8'd0;

    always #5 clk = ~clk;

    // ---------------- DUT outputs (0: default, 1: TX_NUM=2, 2: DEPTH=4) ----------------
    logic        rdy [3];
    logic        dn [3];
    logic        ovf [3];
    logic [31:0] tok_c [3];
    logic [31:0] stp_c [3];
    logic [31:0] cyc_c [3];
    logic [16:0] rdd [3];
    sink_dbg_t   dbg [3];
    logic [8:0]  wp0, wp1;
    logic [2:0]  wp2;

    sparse_stream_sink u_dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush), .data_in(data_in),
        .valid_in(valid_in), .ready_out(rdy[0]), .cfg_stall_period(cfg_p),
        .cfg_stall_len(cfg_l), .rd_addr(rd_addr), .rd_data(rdd[0]),
        .token_count(tok_c[0]), .stop_count(stp_c[0]), .cycle_count(cyc_c[0]),
        .wr_ptr(wp0), .done(dn[0]), .overflow(ovf[0]), .dbg_o(dbg[0])
    );

    sparse_stream_sink #(.TX_NUM(2)) u_tx2 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush), .data_in(data_in),
        .valid_in(valid_in), .ready_out(rdy[1]), .cfg_stall_period(cfg_p),
        .cfg_stall_len(cfg_l), .rd_addr(rd_addr), .rd_data(rdd[1]),
        .token_count(tok_c[1]), .stop_count(stp_c[1]), .cycle_count(cyc_c[1]),
        .wr_ptr(wp1), .done(dn[1]), .overflow(ovf[1]), .dbg_o(dbg[1])
    );

    sparse_stream_sink #(.DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush), .data_in(data_in),
        .valid_in(valid_in), .ready_out(rdy[2]), .cfg_stall_period(cfg_p),
        .cfg_stall_len(cfg_l), .rd_addr(rd_addr[1:0]), .rd_data(rdd[2]),
        .token_count(tok_c[2]), .stop_count(stp_c[2]), .cycle_count(cyc_c[2]),
        .wr_ptr(wp2), .done(dn[2]), .overflow(ovf[2]), .dbg_o(dbg[2])
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int tick_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Stall pattern is a position within a (period + len) window; state 0/1/2 = idle/recv/done.
    int          depth_k [3] = '{256, 256, 4};
    int          tx_k [3]    = '{1, 2, 1};
    int          m_st [3], m_pos [3], m_per [3], m_len [3], m_wp [3], m_dseen [3];
    logic [31:0] m_tok [3], m_stp [3], m_cyc [3];
    bit          m_ovf [3];
    logic [16:0] m_mem [3][256];
    bit          m_mv [3][256];
    logic [16:0] m_rd [3];
    bit          m_rdv [3];
    bit          model_live = 1'b0;

    function automatic bit m_ready(input int k);
        return clk_en && (m_st[k] != 2) &&
               (m_per[k] == 0 || m_len[k] == 0 || m_pos[k] < m_per[k]);
    endfunction

    function automatic logic [8:0] get_wp(input int k);
        if (k == 0) return wp0;
        if (k == 1) return wp1;
        return {6'd0, wp2};
    endfunction

    task automatic model_update();
        bit rdy_m [3];
        for (int k = 0; k < 3; k++) rdy_m[k] = m_ready(k);
        for (int k = 0; k < 3; k++) begin
            if (rst || flush) begin
                m_st[k] = 0; m_pos[k] = 0; m_per[k] = cfg_p; m_len[k] = cfg_l;
                m_wp[k] = 0; m_dseen[k] = 0; m_tok[k] = 0; m_stp[k] = 0; m_cyc[k] = 0;
                m_ovf[k] = 0; m_rd[k] = '0; m_rdv[k] = 1'b1;
            end else if (clk_en) begin
                int  a;
                int  old;
                bit  acc;
                a = rd_addr % depth_k[k];
                m_rd[k]  = m_mem[k][a];
                m_rdv[k] = m_mv[k][a];
                acc = valid_in && rdy_m[k];
                old = m_st[k];
                if (old == 1 || (old == 0 && acc)) m_cyc[k]++;
                if (acc) begin
                    if (m_wp[k] < depth_k[k]) begin
                        m_mem[k][m_wp[k]] = data_in;
                        m_mv[k][m_wp[k]]  = 1'b1;
                        m_wp[k]++;
                    end else begin
                        m_ovf[k] = 1'b1;
                    end
                    if (!data_in[16]) m_tok[k]++;
                    if (data_in[16] && data_in[15:8] == 8'h00) m_stp[k]++;
                    m_st[k] = 1;
                    if (data_in == 17'h10100) begin
                        m_dseen[k]++;
                        if (m_dseen[k] == tx_k[k]) m_st[k] = 2;
                    end
                end
                if (old != 2) begin
                    if (m_per[k] == 0 || m_len[k] == 0) begin
                        m_per[k] = cfg_p; m_len[k] = cfg_l; m_pos[k] = 0;
                    end else begin
                        m_pos[k]++;
                        if (m_pos[k] == m_per[k] + m_len[k]) begin
                            m_pos[k] = 0; m_per[k] = cfg_p; m_len[k] = cfg_l;
                        end
                    end
                end
            end
        end
        if (rst) model_live = 1'b1;
    endtask

    task automatic check_outputs();
        if (!model_live) return;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("ready[%0d]", k), rdy[k], m_ready(k));
            check_eq($sformatf("done[%0d]", k), dn[k], m_st[k] == 2);
            check_eq($sformatf("state[%0d]", k), dbg[k].state, m_st[k]);
            check_eq($sformatf("overflow[%0d]", k), ovf[k], m_ovf[k]);
            check_eq($sformatf("wr_ptr[%0d]", k), get_wp(k), m_wp[k]);
            check_eq($sformatf("token_count[%0d]", k), tok_c[k], m_tok[k]);
            check_eq($sformatf("stop_count[%0d]", k), stp_c[k], m_stp[k]);
            check_eq($sformatf("cycle_count[%0d]", k), cyc_c[k], m_cyc[k]);
            if (m_rdv[k]) check_eq($sformatf("rd_data[%0d]", k), rdd[k], m_rd[k]);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        tick_cnt++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; valid_in = 1'b0; clk_en = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Presents one token and holds it until instance k (per the model) accepts it.
    task automatic send(input logic [16:0] tok, input int k);
        int n;
        bit r;
        n = 0;
        valid_in = 1'b1;
        data_in  = tok;
        do begin
            r = m_ready(k);
            tick();
            n++;
        end while (!r && n < 200);
        check_eq("send_accept", r, 1'b1);
    endtask

    function automatic logic [16:0] gen_token();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 17'h10100;
        if (r <= 2) return {9'h100, 8'($urandom_range(0, 255))};
        if (r == 3) return {1'b1, 8'($urandom_range(2, 255)), 8'($urandom_range(0, 255))};
        return {1'b0, 16'($urandom_range(0, 65535))};
    endfunction

    logic [16:0] t2_tok [7];

    // ---------------- test sequence ----------------
    initial begin
        int t0;
        @(negedge clk);

        // Test 1: no stalls, back-to-back stream, reaches done in 4 cycles.
        cfg_p = 8'd0; cfg_l = 8'd0;
        do_reset();
        check_eq("t1_reset_tokens", tok_c[0], 32'd0);
        t0 = tick_cnt;
        send(17'd5, 0); send(17'd7, 0); send(17'h10000, 0); send(17'h10100, 0);
        valid_in = 1'b0;
        check_eq("t1_latency", tick_cnt - t0, 4);
        check_eq("t1_done", dn[0], 1'b1);
        check_eq("t1_token_count", tok_c[0], 32'd2);
        check_eq("t1_stop_count", stp_c[0], 32'd1);
        check_eq("t1_wr_ptr", wp0, 9'd4);
        check_eq("t1_cycle_count", cyc_c[0], 32'd4);
        rd_addr = 8'd3;
        tick();
        check_eq("t1_mem3", rdd[0], 17'h10100);

        // Test 2: ready pattern 1,1,0 with valid held high.
        cfg_p = 8'd2; cfg_l = 8'd1;
        do_reset();
        for (int i = 0; i < 6; i++) t2_tok[i] = 17'(16'h0a10 + i);
        t2_tok[6] = 17'h10100;
        for (int i = 0; i < 7; i++) send(t2_tok[i], 0);
        valid_in = 1'b0;
        check_eq("t2_cycle_count", cyc_c[0], 32'd10);
        check_eq("t2_wr_ptr", wp0, 9'd7);
        check_eq("t2_done", dn[0], 1'b1);
        for (int i = 0; i < 7; i++) begin
            rd_addr = 8'(i);
            tick();
            check_eq($sformatf("t2_mem%0d", i), rdd[0], t2_tok[i]);
        end

        // Test 3: TX_NUM = 2 needs both DONE tokens.
        cfg_p = 8'd0; cfg_l = 8'd0;
        do_reset();
        send(17'd1, 1); send(17'h10100, 1);
        valid_in = 1'b0;
        tick();
        check_eq("t3_done_early", dn[1], 1'b0);
        check_eq("t3_inst0_done", dn[0], 1'b1);
        send(17'd2, 1); send(17'h10100, 1);
        valid_in = 1'b0;
        tick();
        check_eq("t3_done", dn[1], 1'b1);
        check_eq("t3_wr_ptr", wp1, 9'd4);
        check_eq("t3_ready", rdy[1], 1'b0);

        // Test 4: DEPTH = 4 overflows but keeps counting.
        do_reset();
        for (int i = 0; i < 6; i++) send(17'(100 + i), 2);
        send(17'h10100, 2);
        valid_in = 1'b0;
        check_eq("t4_overflow", ovf[2], 1'b1);
        check_eq("t4_wr_ptr", wp2, 3'd4);
        check_eq("t4_token_count", tok_c[2], 32'd6);
        check_eq("t4_done", dn[2], 1'b1);

        // Test 5: flush coincident with the third token.
        do_reset();
        send(17'd11, 0); send(17'd12, 0);
        data_in = 17'd13; valid_in = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; valid_in = 1'b0;
        check_eq("t5_token_count", tok_c[0], 32'd0);
        check_eq("t5_cycle_count", cyc_c[0], 32'd0);
        check_eq("t5_wr_ptr", wp0, 9'd0);
        check_eq("t5_state", dbg[0].state, IDLE);
        send(17'd21, 0); send(17'h10100, 0);
        valid_in = 1'b0;
        rd_addr = 8'd0;
        tick();
        check_eq("t5_mem0", rdd[0], 17'd21);
        check_eq("t5_token_count2", tok_c[0], 32'd1);

        // Test 6: reset from DONE, then clk_en freeze.
        do_reset();
        send(17'd3, 0); send(17'h10100, 0);
        valid_in = 1'b0;
        check_eq("t6_done_before", dn[0], 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_eq("t6_done", dn[0], 1'b0);
        check_eq("t6_ready", rdy[0], 1'b1);
        check_eq("t6_token_count", tok_c[0], 32'd0);
        check_eq("t6_cycle_count", cyc_c[0], 32'd0);
        send(17'd4, 0);
        clk_en = 1'b0; valid_in = 1'b1; data_in = 17'd5;
        repeat (5) tick();
        #1;
        check_eq("t6_frozen_ready", rdy[0], 1'b0);
        check_eq("t6_frozen_cycles", cyc_c[0], 32'd1);
        check_eq("t6_frozen_tokens", tok_c[0], 32'd1);
        clk_en = 1'b1; valid_in = 1'b0;
        tick();

        // Randomised episodes against the model.
        for (int ep = 0; ep < 25; ep++) begin
            cfg_p = 8'($urandom_range(0, 4));
            cfg_l = 8'($urandom_range(0, 3));
            clk_en = 1'b1; valid_in = 1'b0;
            if ($urandom_range(0, 1) == 0) begin
                rst = 1'b1; tick(); rst = 1'b0;
            end else begin
                flush = 1'b1; tick(); flush = 1'b0;
            end
            for (int c = 0; c < 80; c++) begin
                valid_in = ($urandom_range(0, 3) != 0);
                data_in  = gen_token();
                clk_en   = ($urandom_range(0, 9) != 0);
                flush    = ($urandom_range(0, 63) == 0);
                rd_addr  = 8'($urandom_range(0, 15));
                tick();
            end
            flush = 1'b0;
        end
        clk_en = 1'b1; valid_in = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
